// File: rtl/risc_v_mem_pkg.sv
// Shared definitions for the RISC-V data memory: access-size codes, controller
// states and the byte-lane write-mask helper.
// Latency: none (types and pure functions only). Backpressure: n/a.
package risc_v_mem_pkg;

  // Widest row the lane-mask helper supports (512-bit data bus).
  localparam int MAX_LANES = 64;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BUSY = 2'b01,
    ST_RESP = 2'b10
  } mem_state_e;

  // Byte-lane enables for an access of the given size starting at byte_off
  // within a row. The reserved size enables no lanes. Callers truncate the
  // result to their own lane count.
  function automatic logic [MAX_LANES-1:0] lane_mask(input mem_size_e size,
                                                     input logic [5:0] byte_off);
    logic [MAX_LANES-1:0] base;
    base = '0;
    case (size)
      SIZE_BYTE: base[0]   = 1'b1;
      SIZE_HALF: base[1:0] = 2'b11;
      SIZE_WORD: base[3:0] = 4'hF;
      default:   base      = '0;
    endcase
    return base << byte_off;
  endfunction

endpackage

// File: rtl/risc_v_data_mem_if.sv
// Request/response bus between a load-store unit and the data memory.
// Latency: wires only. Backpressure: req_valid/req_ready and resp_valid/resp_ready.
// Ports: master drives req_* and resp_ready; slave drives req_ready and resp_*.
interface risc_v_data_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_write;
  logic [1:0]            req_size;
  logic                  req_unsigned;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [DATA_WIDTH-1:0] resp_rdata;
  logic                  resp_err;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/risc_v_mem_lane_align.sv
// Byte-lane steering: store lane enables/data placement and load extraction/extension.
// Latency: combinational. Backpressure: none.
// Ports: size_i/unsigned_i/byte_off_i describe the access; wdata_i is right-aligned
// store data; row_i is the addressed storage row; outputs are lane_we_o,
// wdata_row_o (store data in row position) and load_data_o (extended load value).
module risc_v_mem_lane_align
  import risc_v_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int OFF_W      = 2
) (
  input  mem_size_e               size_i,
  input  logic                    unsigned_i,
  input  logic [OFF_W-1:0]        byte_off_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  input  logic [DATA_WIDTH-1:0]   row_i,
  output logic [DATA_WIDTH/8-1:0] lane_we_o,
  output logic [DATA_WIDTH-1:0]   wdata_row_o,
  output logic [DATA_WIDTH-1:0]   load_data_o
);

  localparam int LANES = DATA_WIDTH / 8;

  logic [OFF_W+2:0]      bit_sh;
  logic [DATA_WIDTH-1:0] shifted;
  logic [DATA_WIDTH-1:0] keep;
  logic                  sign_bit;

  assign bit_sh      = {byte_off_i, 3'b000};
  assign lane_we_o   = LANES'(lane_mask(size_i, 6'(byte_off_i)));
  assign wdata_row_o = wdata_i << bit_sh;

  // Bring the addressed bytes down to bit 0, keep the access width and fill
  // the rest with either zeros or copies of the access's top bit. Words are
  // extended from bit 31 too, which only matters on buses wider than 32.
  always_comb begin
    shifted  = row_i >> bit_sh;
    keep     = '0;
    sign_bit = 1'b0;
    case (size_i)
      SIZE_BYTE: begin keep[7:0]  = '1; sign_bit = shifted[7];  end
      SIZE_HALF: begin keep[15:0] = '1; sign_bit = shifted[15]; end
      SIZE_WORD: begin keep[31:0] = '1; sign_bit = shifted[31]; end
      default:   begin keep       = '0; sign_bit = 1'b0;        end
    endcase
    load_data_o = (shifted & keep) | ((sign_bit && !unsigned_i) ? ~keep : '0);
  end

endmodule

// File: rtl/risc_v_data_mem.sv
// Single-outstanding RISC-V data memory with byte/half/word access and error detection.
// Latency: resp_valid rises LATENCY cycles after the accepting cycle.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
// Ports: clk, rst_n (async active-low), bus (slave side of risc_v_data_mem_if).
module risc_v_data_mem
  import risc_v_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int MEM_WORDS  = 256,
  parameter int LATENCY    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  risc_v_data_mem_if.slave bus
);

  localparam int LANES     = DATA_WIDTH / 8;
  localparam int OFF_W     = $clog2(LANES);
  localparam int IDX_W     = ADDR_WIDTH - OFF_W;
  localparam int MEM_IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  // Counter only has to hold LATENCY-2, the extra BUSY cycles beyond the first.
  localparam int CNT_W     = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CNT_W-1:0] BUSY_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);
  localparam logic [IDX_W:0]   WORDS_LIM = (IDX_W + 1)'(MEM_WORDS);

  // Storage: deliberately not reset.
  logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

  mem_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  mem_size_e             size;
  logic [OFF_W-1:0]      byte_off;
  logic [IDX_W-1:0]      word_idx;
  logic [MEM_IDX_W-1:0]  mem_idx;
  logic                  req_err;
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_row;
  logic [LANES-1:0]      lane_we;
  logic [DATA_WIDTH-1:0] wdata_row;
  logic [DATA_WIDTH-1:0] load_data;

  assign size     = mem_size_e'(bus.req_size);
  assign byte_off = bus.req_addr[OFF_W-1:0];
  assign word_idx = bus.req_addr[ADDR_WIDTH-1:OFF_W];
  assign mem_idx  = MEM_IDX_W'(word_idx);
  assign accept   = bus.req_valid && (state_q == ST_IDLE);
  assign rd_row   = mem_q[mem_idx];

  // Alignment is checked against the access size alone, so a word access on a
  // wider bus may sit in any 4-byte-aligned slot of the row.
  always_comb begin
    req_err = 1'b0;
    case (size)
      SIZE_HALF: req_err = bus.req_addr[0];
      SIZE_WORD: req_err = |bus.req_addr[1:0];
      SIZE_RSVD: req_err = 1'b1;
      default:   req_err = 1'b0;
    endcase
    if ({1'b0, word_idx} >= WORDS_LIM) begin
      req_err = 1'b1;
    end
  end

  risc_v_mem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .OFF_W      (OFF_W)
  ) u_lane_align (
    .size_i      (size),
    .unsigned_i  (bus.req_unsigned),
    .byte_off_i  (byte_off),
    .wdata_i     (bus.req_wdata),
    .row_i       (rd_row),
    .lane_we_o   (lane_we),
    .wdata_row_o (wdata_row),
    .load_data_o (load_data)
  );

  // Stores land on the accepting edge; errored requests never touch storage.
  always_ff @(posedge clk) begin
    if (accept && bus.req_write && !req_err) begin
      for (int l = 0; l < LANES; l++) begin
        if (lane_we[l]) begin
          mem_q[mem_idx][l*8 +: 8] <= wdata_row[l*8 +: 8];
        end
      end
    end
  end

  // The load result is captured at acceptance, so it is already frozen for
  // the whole of BUSY and RESP and later stores cannot disturb it.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    rdata_d        = rdata_q;
    err_d          = err_q;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept) begin
          rdata_d = (req_err || bus.req_write) ? '0 : load_data;
          err_d   = req_err;
          cnt_d   = BUSY_LOAD;
          state_d = (LATENCY == 1) ? ST_RESP : ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_risc_v_data_mem.sv
// Testbench for risc_v_data_mem: directed scenarios plus randomized traffic
// checked against a byte-array reference model.
// Runs with MEM_WORDS=192 so the top of the address space is out of range.
module tb_risc_v_data_mem;
  import risc_v_mem_pkg::*;

  localparam int DW  = 32;
  localparam int AW  = 10;
  localparam int MW  = 192;
  localparam int LAT = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  risc_v_data_mem_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  risc_v_data_mem #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .MEM_WORDS  (MW),
    .LATENCY    (LAT)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ref_mem [MW*4];

  // Reference model: byte-addressed memory, rules applied directly.
  task automatic model_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           output logic [DW-1:0] exp_rd, output logic exp_err);
    int a;
    int nbytes;
    logic [63:0] v;
    a       = int'(addr);
    exp_rd  = '0;
    exp_err = (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) ||
              (sz == 2'd2 && (a % 4) != 0) || ((a / 4) >= MW);
    if (exp_err) return;
    nbytes = 1 << sz;
    if (wr) begin
      for (int b = 0; b < nbytes; b++) ref_mem[a+b] = wd[8*b +: 8];
    end else begin
      v = '0;
      for (int b = 0; b < nbytes; b++) v = v | (64'(ref_mem[a+b]) << (8*b));
      if (!uns && v[8*nbytes-1]) v = v | ~((64'd1 << (8*nbytes)) - 64'd1);
      exp_rd = v[DW-1:0];
    end
  endtask

  // Drives one transaction and reports what was observed; called and returns
  // 1 time unit after a rising edge. bad counts cycles where req_ready was high
  // while outstanding or the held response moved.
  task automatic drive_txn(input logic wr, input logic [1:0] sz, input logic uns,
                           input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                           input int hold, output int lat, output logic [DW-1:0] rd,
                           output logic er, output int bad, output logic rdy_before,
                           output logic idle_after);
    bus.req_write    = wr;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wd;
    bus.req_valid    = 1'b1;
    bus.resp_ready   = (hold == 0);
    rdy_before       = bus.req_ready;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_wdata = $urandom;
    bad = 0;
    lat = 1;
    while (bus.resp_valid !== 1'b1 && lat < 20) begin
      if (bus.req_ready !== 1'b0) bad++;
      @(posedge clk); #1;
      lat++;
    end
    if (bus.req_ready !== 1'b0) bad++;
    rd = bus.resp_rdata;
    er = bus.resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== rd ||
          bus.resp_err !== er || bus.req_ready !== 1'b0) bad++;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    idle_after = (bus.resp_valid === 1'b0) && (bus.req_ready === 1'b1);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 ||
        bus.resp_rdata !== '0 || bus.resp_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b ready=%b rdata=%h err=%b, want 0 1 0 0",
               bus.resp_valid, bus.req_ready, bus.resp_rdata, bus.resp_err);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: valid=%b ready=%b, want 0 1", bus.resp_valid, bus.req_ready);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] e, rd, wd;
    logic ee, er, rb, ia;
    int lat, bad;
    for (int w = 0; w < MW; w++) begin
      wd = $urandom;
      model_txn(1'b1, 2'd2, 1'b0, AW'(w*4), wd, e, ee);
      drive_txn(1'b1, 2'd2, 1'b0, AW'(w*4), wd, 0, lat, rd, er, bad, rb, ia);
      n_checks++;
      if (rd !== e || er !== ee || lat != LAT) begin
        n_fail++;
        $display("FAIL fill_store[%0d]: rdata=%h err=%b lat=%0d, want %h %b %0d",
                 w, rd, er, lat, e, ee, LAT);
      end
    end
  endtask

  task automatic test_word_store_load();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    model_txn(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, e, ee);
    drive_txn(1'b1, 2'd2, 1'b0, 10'h010, 32'hDEADBEEF, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (lat != LAT || rd !== 32'h0 || er !== 1'b0 || bad != 0 || rb !== 1'b1 || ia !== 1'b1) begin
      n_fail++;
      $display("FAIL word_store: lat=%0d rdata=%h err=%b bad=%0d rdy=%b idle=%b, want %0d 0 0 0 1 1",
               lat, rd, er, bad, rb, ia, LAT);
    end
    model_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (lat != LAT || rd !== 32'hDEADBEEF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL word_load: lat=%0d rdata=%h err=%b, want %0d deadbeef 0", lat, rd, er, LAT);
    end
  endtask

  task automatic test_extension();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    logic [1:0]    sz [4]  = '{2'd0, 2'd1, 2'd1, 2'd0};
    logic          un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [AW-1:0] ad [4]  = '{10'h013, 10'h010, 10'h012, 10'h013};
    logic [DW-1:0] ex [4]  = '{32'hFFFFFFDE, 32'h0000BEEF, 32'hFFFFDEAD, 32'h000000DE};
    for (int i = 0; i < 4; i++) begin
      model_txn(1'b0, sz[i], un[i], ad[i], 32'h0, e, ee);
      drive_txn(1'b0, sz[i], un[i], ad[i], 32'h0, 0, lat, rd, er, bad, rb, ia);
      n_checks++;
      if (rd !== ex[i] || er !== 1'b0) begin
        n_fail++;
        $display("FAIL extend[%0d]: rdata=%h err=%b, want %h 0", i, rd, er, ex[i]);
      end
    end
  endtask

  task automatic test_byte_store();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    model_txn(1'b1, 2'd0, 1'b0, 10'h011, 32'hA5A5A555, e, ee);
    drive_txn(1'b1, 2'd0, 1'b0, 10'h011, 32'hA5A5A555, 0, lat, rd, er, bad, rb, ia);
    model_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL byte_store: rdata=%h err=%b, want dead55ef 0", rd, er);
    end
  endtask

  task automatic test_errors();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    // write, size, address: misaligned half store, misaligned word load,
    // reserved size, first out-of-range word, out-of-range byte store
    logic          wr [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [1:0]    sz [5] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd0};
    logic [AW-1:0] ad [5] = '{10'h011, 10'h012, 10'h010, 10'h300, 10'h320};
    for (int i = 0; i < 5; i++) begin
      model_txn(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_AAAA, e, ee);
      drive_txn(wr[i], sz[i], 1'b0, ad[i], 32'hFFFF_AAAA, 0, lat, rd, er, bad, rb, ia);
      n_checks++;
      if (rd !== 32'h0 || er !== 1'b1 || lat != LAT) begin
        n_fail++;
        $display("FAIL error[%0d]: rdata=%h err=%b lat=%0d, want 0 1 %0d", i, rd, er, lat, LAT);
      end
    end
    model_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0) begin
      n_fail++;
      $display("FAIL after_misaligned: rdata=%h err=%b, want dead55ef 0", rd, er);
    end
    // Last in-range word.
    model_txn(1'b0, 2'd2, 1'b0, 10'h2FC, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h2FC, 32'h0, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (rd !== e || er !== 1'b0) begin
      n_fail++;
      $display("FAIL last_word: rdata=%h err=%b, want %h 0", rd, er, e);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    model_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h010, 32'h0, 5, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (rd !== 32'hDEAD55EF || er !== 1'b0 || lat != LAT) begin
      n_fail++;
      $display("FAIL bp_data: rdata=%h err=%b lat=%0d, want dead55ef 0 %0d", rd, er, lat, LAT);
    end
    n_checks++;
    if (bad != 0 || ia !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: unstable_cycles=%0d ready_after=%b, want 0 1", bad, ia);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] e, rd;
    logic ee, er, rb, ia;
    int lat, bad;
    int seen = 0;
    model_txn(1'b1, 2'd2, 1'b0, 10'h020, 32'h12345678, e, ee);
    bus.req_write    = 1'b1;
    bus.req_size     = 2'd2;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = 10'h020;
    bus.req_wdata    = 32'h12345678;
    bus.req_valid    = 1'b1;
    bus.resp_ready   = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_busy: valid=%b ready=%b, want 0 0", bus.resp_valid, bus.req_ready);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b ready=%b, want 0 1", bus.resp_valid, bus.req_ready);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.resp_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL mid_no_resp: stray response cycles=%0d, want 0", seen);
    end
    model_txn(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, e, ee);
    drive_txn(1'b0, 2'd2, 1'b0, 10'h020, 32'h0, 0, lat, rd, er, bad, rb, ia);
    n_checks++;
    if (rd !== 32'h12345678 || er !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_store_kept: rdata=%h err=%b, want 12345678 0", rd, er);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] e, rd, wd;
    logic ee, er, rb, ia, wr, un;
    logic [1:0] sz;
    logic [AW-1:0] ad;
    int lat, bad, hold;
    for (int i = 0; i < 300; i++) begin
      wr   = 1'($urandom_range(0, 1));
      un   = 1'($urandom_range(0, 1));
      sz   = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ad   = AW'($urandom_range(0, (1 << AW) - 1));
      if ($urandom_range(0, 3) != 0) ad = ad & ~AW'((1 << sz) - 1);
      wd   = $urandom;
      hold = $urandom_range(0, 2);
      model_txn(wr, sz, un, ad, wd, e, ee);
      drive_txn(wr, sz, un, ad, wd, hold, lat, rd, er, bad, rb, ia);
      n_checks++;
      if (rd !== e || er !== ee) begin
        n_fail++;
        $display("FAIL rand_data[%0d] wr=%b sz=%0d u=%b addr=%h: rdata=%h err=%b, want %h %b",
                 i, wr, sz, un, ad, rd, er, e, ee);
      end
      n_checks++;
      if (lat != LAT || bad != 0 || rb !== 1'b1 || ia !== 1'b1) begin
        n_fail++;
        $display("FAIL rand_proto[%0d]: lat=%0d bad=%0d rdy=%b idle=%b, want %0d 0 1 1",
                 i, lat, bad, rb, ia, LAT);
      end
    end
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_size     = 2'd0;
    bus.req_unsigned = 1'b0;
    bus.req_addr     = '0;
    bus.req_wdata    = '0;
    bus.resp_ready   = 1'b1;
    test_reset();
    test_fill();
    test_word_store_load();
    test_extension();
    test_byte_store();
    test_errors();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
